// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes RV32I opcode/funct fields into an ALU operation and registers operands.
// Optional operand forwarding is compiled in with ALU_OPERAND_FORWARD_EN.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            inValid,
  output logic            inReady,
  input  logic [XLEN-1:0] pc,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [4:0]      rs1Addr,
  input  logic [4:0]      rs2Addr,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] in1,
  output logic [XLEN-1:0] in2,
  output logic [3:0]      aluOperation,
  output logic [XLEN-1:0] storeData,
  output logic [4:0]      rdOut,
  output logic            isBranch,
  output logic            illegal,
  input  logic            exMemRegWrite,
  input  logic            memWbRegWrite,
  input  logic [4:0]      exMemRd,
  input  logic [4:0]      memWbRd,
  input  logic [XLEN-1:0] exMemResult,
  input  logic [XLEN-1:0] memWbResult
);

  localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4,  ALU_SLL  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8,  ALU_SLTU = 4'd9,  ALU_BEQ  = 4'd10, ALU_BNE  = 4'd11;
  localparam logic [3:0] ALU_BLT  = 4'd12, ALU_BGE  = 4'd13, ALU_BLTU = 4'd14, ALU_BGEU = 4'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic            valid_reg, valid_next;
  logic [XLEN-1:0] in1_reg, in1_next;
  logic [XLEN-1:0] in2_reg, in2_next;
  logic [XLEN-1:0] store_reg;
  logic [3:0]      op_reg, op_next;
  logic [4:0]      rd_reg;
  logic            branch_reg, branch_next;
  logic            illegal_reg, illegal_next;
  logic            load;
  logic [XLEN-1:0] rs1_val, rs2_val;

`ifdef ALU_OPERAND_FORWARD_EN
  // Newest producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] addr, input logic [XLEN-1:0] rf);
    if (exMemRegWrite && exMemRd == addr && addr != 5'd0)
      return exMemResult;
    else if (memWbRegWrite && memWbRd == addr && addr != 5'd0)
      return memWbResult;
    else
      return rf;
  endfunction

  assign rs1_val = fwd(rs1Addr, rs1Data);
  assign rs2_val = fwd(rs2Addr, rs2Data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs1Addr, rs2Addr, exMemRegWrite, memWbRegWrite, exMemRd, memWbRd,
                        exMemResult, memWbResult};
  assign rs1_val = rs1Data;
  assign rs2_val = rs2Data;
`endif

  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  assign inReady = !valid_reg || outReady;
  assign load    = inValid && inReady && !flush;

  always_comb begin
    valid_next = valid_reg;
    if (flush)
      valid_next = 1'b0;
    else if (load)
      valid_next = 1'b1;
    else if (outReady)
      valid_next = 1'b0;
  end

  always_comb begin
    op_next      = ALU_ADD;
    in1_next     = '0;
    in2_next     = '0;
    branch_next  = 1'b0;
    illegal_next = 1'b0;
    case (opcode)
      OP_R: begin
        in1_next = rs1_val;
        in2_next = rs2_val;
        op_next  = arith_op(funct3, funct7b5);
      end
      OP_I: begin
        in1_next = rs1_val;
        in2_next = imm;
        op_next  = (funct3 == 3'b000) ? ALU_ADD : arith_op(funct3, funct7b5);
      end
      OP_LOAD, OP_STORE: begin
        in1_next = rs1_val;
        in2_next = imm;
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  op_next = ALU_BEQ;
          3'b001:  op_next = ALU_BNE;
          3'b100:  op_next = ALU_BLT;
          3'b101:  op_next = ALU_BGE;
          3'b110:  op_next = ALU_BLTU;
          3'b111:  op_next = ALU_BGEU;
          default: illegal_next = 1'b1;
        endcase
        // An unsupported branch encoding is issued as an inert ADD 0,0.
        if (!illegal_next) begin
          in1_next    = rs1_val;
          in2_next    = rs2_val;
          branch_next = 1'b1;
        end
      end
      OP_LUI:   in2_next = imm;
      OP_AUIPC: begin
        in1_next = pc;
        in2_next = imm;
      end
      OP_JAL, OP_JALR: begin
        in1_next = pc;
        in2_next = XLEN'(4);
      end
      default: illegal_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      in1_reg     <= '0;
      in2_reg     <= '0;
      store_reg   <= '0;
      op_reg      <= ALU_ADD;
      rd_reg      <= '0;
      branch_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      if (load) begin
        in1_reg     <= in1_next;
        in2_reg     <= in2_next;
        store_reg   <= rs2_val;
        op_reg      <= op_next;
        rd_reg      <= rd;
        branch_reg  <= branch_next;
        illegal_reg <= illegal_next;
      end
    end
  end

  assign outValid     = valid_reg;
  assign in1          = in1_reg;
  assign in2          = in2_reg;
  assign storeData    = store_reg;
  assign aluOperation = op_reg;
  assign rdOut        = rd_reg;
  assign isBranch     = branch_reg;
  assign illegal      = illegal_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; forwarding cases follow ALU_OPERAND_FORWARD_EN.
module tb_alu_issue_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset, flush, inValid, inReady, funct7b5;
  logic [XLEN-1:0] pc, rs1Data, rs2Data, imm;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1Addr, rs2Addr, rd, rdOut;
  logic            outValid, outReady, isBranch, illegal;
  logic [XLEN-1:0] in1, in2, storeData;
  logic [3:0]      aluOperation;
  logic            exMemRegWrite, memWbRegWrite;
  logic [4:0]      exMemRd, memWbRd;
  logic [XLEN-1:0] exMemResult, memWbResult;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush), .inValid(inValid), .inReady(inReady),
    .pc(pc), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .imm(imm), .rd(rd), .outValid(outValid), .outReady(outReady),
    .in1(in1), .in2(in2), .aluOperation(aluOperation), .storeData(storeData),
    .rdOut(rdOut), .isBranch(isBranch), .illegal(illegal),
    .exMemRegWrite(exMemRegWrite), .memWbRegWrite(memWbRegWrite),
    .exMemRd(exMemRd), .memWbRd(memWbRd),
    .exMemResult(exMemResult), .memWbResult(memWbResult)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                       input logic [XLEN-1:0] im, input logic [4:0] rdv);
    opcode = op; funct3 = f3; funct7b5 = f7;
    rs1Data = d1; rs2Data = d2; imm = im; rd = rdv;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    pc = 32'h1000; rs1Addr = 5'd1; rs2Addr = 5'd2;
    exMemRegWrite = 1'b0; memWbRegWrite = 1'b0; exMemRd = 5'd0; memWbRd = 5'd0;
    exMemResult = '0; memWbResult = '0;
    instr(7'b0110011, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick(); tick();

    check("rst_valid", 32'(outValid), 32'd0);
    check("rst_in1", in1, 32'd0);
    check("rst_in2", in2, 32'd0);
    check("rst_op", 32'(aluOperation), 32'd0);
    check("rst_store", storeData, 32'd0);
    check("rst_rd", 32'(rdOut), 32'd0);
    check("rst_branch", 32'(isBranch), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_inready", 32'(inReady), 32'd1);
    $display("txn reset done");

    reset = 1'b0; inValid = 1'b1;
    instr(7'b0110011, 3'b000, 1'b1, 32'd7, 32'd3, 32'd0, 5'd9);
    tick();
    check("sub_valid", 32'(outValid), 32'd1);
    check("sub_op", 32'(aluOperation), 32'd1);
    check("sub_in1", in1, 32'd7);
    check("sub_in2", in2, 32'd3);
    check("sub_rd", 32'(rdOut), 32'd9);
    $display("txn R-type SUB op=%0d in1=%0d in2=%0d", aluOperation, in1, in2);

    instr(7'b0010011, 3'b101, 1'b1, 32'h80, 32'd0, 32'd4, 5'd10);
    tick();
    check("srai_op", 32'(aluOperation), 32'd7);
    check("srai_in1", in1, 32'h80);
    check("srai_in2", in2, 32'd4);
    $display("txn I-type SRAI op=%0d", aluOperation);

    instr(7'b0010011, 3'b101, 1'b0, 32'h80, 32'd0, 32'd4, 5'd10);
    tick();
    check("srli_op", 32'(aluOperation), 32'd6);
    $display("txn I-type SRLI op=%0d", aluOperation);

    instr(7'b0010011, 3'b000, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 5'd11);
    tick();
    check("addi_op", 32'(aluOperation), 32'd0);
    check("addi_in2", in2, 32'hFFFF_FFFF);
    $display("txn I-type ADDI op=%0d", aluOperation);

    instr(7'b1100011, 3'b111, 1'b0, 32'd12, 32'd34, 32'd0, 5'd0);
    tick();
    check("bgeu_op", 32'(aluOperation), 32'd15);
    check("bgeu_branch", 32'(isBranch), 32'd1);
    check("bgeu_in2", in2, 32'd34);
    check("bgeu_illegal", 32'(illegal), 32'd0);
    $display("txn BRANCH BGEU op=%0d", aluOperation);

    instr(7'b1100011, 3'b010, 1'b0, 32'd12, 32'd34, 32'd0, 5'd0);
    tick();
    check("bill_illegal", 32'(illegal), 32'd1);
    check("bill_op", 32'(aluOperation), 32'd0);
    $display("txn BRANCH funct3=010 illegal=%0d", illegal);

    instr(7'b0100011, 3'b010, 1'b0, 32'd100, 32'h0000_DEAD, 32'd8, 5'd0);
    tick();
    check("sw_op", 32'(aluOperation), 32'd0);
    check("sw_in1", in1, 32'd100);
    check("sw_in2", in2, 32'd8);
    check("sw_store", storeData, 32'h0000_DEAD);
    $display("txn STORE storeData=0x%0h", storeData);

    instr(7'b0110111, 3'b000, 1'b0, 32'd55, 32'd0, 32'h1234_5000, 5'd12);
    tick();
    check("lui_in1", in1, 32'd0);
    check("lui_in2", in2, 32'h1234_5000);
    $display("txn LUI in2=0x%0h", in2);

    instr(7'b0010111, 3'b000, 1'b0, 32'd55, 32'd0, 32'h0000_2000, 5'd13);
    tick();
    check("auipc_in1", in1, 32'h1000);
    check("auipc_in2", in2, 32'h2000);
    $display("txn AUIPC in1=0x%0h", in1);

    instr(7'b1101111, 3'b000, 1'b0, 32'd55, 32'd0, 32'h40, 5'd1);
    tick();
    check("jal_in1", in1, 32'h1000);
    check("jal_in2", in2, 32'd4);
    check("jal_op", 32'(aluOperation), 32'd0);
    $display("txn JAL in2=%0d", in2);

    instr(7'b1111111, 3'b000, 1'b0, 32'd55, 32'd66, 32'd77, 5'd2);
    tick();
    check("bad_illegal", 32'(illegal), 32'd1);
    check("bad_in1", in1, 32'd0);
    check("bad_in2", in2, 32'd0);
    check("bad_branch", 32'(isBranch), 32'd0);
    $display("txn bad opcode illegal=%0d", illegal);

    // Stall: A is held for three cycles while B waits at the input.
    instr(7'b0110011, 3'b110, 1'b0, 32'd1, 32'd2, 32'd0, 5'd3);
    tick();
    outReady = 1'b0;
    instr(7'b0110011, 3'b100, 1'b0, 32'd50, 32'd60, 32'd0, 5'd4);
    #1;
    check("stall_inready", 32'(inReady), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(outValid), 32'd1);
      check("stall_in1", in1, 32'd1);
      check("stall_op", 32'(aluOperation), 32'd3);
      check("stall_rd", 32'(rdOut), 32'd3);
      $display("txn stall cycle %0d rdOut=%0d", i, rdOut);
    end
    outReady = 1'b1;
    #1;
    check("release_inready", 32'(inReady), 32'd1);
    tick();
    check("b_rd", 32'(rdOut), 32'd4);
    check("b_in1", in1, 32'd50);
    check("b_op", 32'(aluOperation), 32'd4);
    inValid = 1'b0;
    tick();
    check("drain_valid", 32'(outValid), 32'd0);
    $display("txn stall release rdOut=%0d", rdOut);

    // Flush while FULL with a new instruction offered.
    inValid = 1'b1;
    instr(7'b0110011, 3'b000, 1'b0, 32'd21, 32'd22, 32'd0, 5'd5);
    tick();
    check("c_valid", 32'(outValid), 32'd1);
    flush = 1'b1;
    instr(7'b0110011, 3'b111, 1'b0, 32'd31, 32'd32, 32'd0, 5'd7);
    tick();
    check("flush_valid", 32'(outValid), 32'd0);
    flush = 1'b0; inValid = 1'b0;
    tick();
    check("flush_valid2", 32'(outValid), 32'd0);
    check("flush_rd", 32'(rdOut), 32'd5);
    $display("txn flush outValid=%0d", outValid);

    // Reset during a stall drops the held instruction.
    inValid = 1'b1; outReady = 1'b0;
    instr(7'b0110011, 3'b001, 1'b0, 32'd41, 32'd42, 32'd0, 5'd6);
    tick();
    check("pre_rst_valid", 32'(outValid), 32'd1);
    reset = 1'b1; flush = 1'b1;
    tick();
    check("midrst_valid", 32'(outValid), 32'd0);
    check("midrst_in1", in1, 32'd0);
    check("midrst_rd", 32'(rdOut), 32'd0);
    reset = 1'b0; flush = 1'b0; outReady = 1'b1;
    $display("txn reset mid-stall outValid=%0d", outValid);

    // Forwarding sources all point at x5.
    rs1Addr = 5'd5;
    exMemRd = 5'd5; memWbRd = 5'd5; exMemRegWrite = 1'b1; memWbRegWrite = 1'b1;
    exMemResult = 32'hAA; memWbResult = 32'hBB;
    instr(7'b0110011, 3'b000, 1'b0, 32'h11, 32'h22, 32'd0, 5'd8);
    tick();
`ifdef ALU_OPERAND_FORWARD_EN
    check("fwd_exmem", in1, 32'hAA);
    exMemRegWrite = 1'b0;
    tick();
    check("fwd_memwb", in1, 32'hBB);
    rs1Addr = 5'd0; exMemRegWrite = 1'b1;
    tick();
    check("fwd_x0", in1, 32'h11);
`else
    check("nofwd_in1", in1, 32'h11);
    rs1Addr = 5'd0;
    tick();
    check("nofwd_x0", in1, 32'h11);
`endif
    $display("txn forwarding in1=0x%0h", in1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
